// File: rtl/prbs_pkg.sv
// prbs_pkg: shared types, default polynomials and the feedback function for
// the PRBS generator/checker pair.
package prbs_pkg;

    localparam int ERR_CNT_W = 16;

    typedef enum logic {
        SYNC = 1'b0,
        LOCK = 1'b1
    } chk_state_t;

    // Default maximal-length tap masks (bit i set = state bit i feeds the XOR)
    localparam logic [6:0]  PRBS7_TAPS  = 7'h60;
    localparam logic [7:0]  PRBS8_TAPS  = 8'hB8;
    localparam logic [14:0] PRBS15_TAPS = 15'h6000;
    localparam logic [15:0] PRBS16_TAPS = 16'hB400;
    localparam logic [22:0] PRBS23_TAPS = 23'h420000;
    localparam logic [30:0] PRBS31_TAPS = 31'h48000000;

    // Default nonzero seeds
    localparam logic [6:0]  PRBS7_SEED  = 7'h01;
    localparam logic [7:0]  PRBS8_SEED  = 8'h01;
    localparam logic [14:0] PRBS15_SEED = 15'h0001;
    localparam logic [15:0] PRBS16_SEED = 16'h0001;
    localparam logic [22:0] PRBS23_SEED = 23'h000001;
    localparam logic [30:0] PRBS31_SEED = 31'h00000001;

    // Tap-masked XOR reduction; callers zero-extend their state and taps to 32 bits
    function automatic logic prbs_fb(input logic [31:0] state, input logic [31:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/prbs_chk.sv
// prbs_chk: self-synchronising PRBS checker. Fills its shift state from the
// received stream, then free-runs its own LFSR and compares every valid bit.
module prbs_chk
    import prbs_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS        = PRBS8_TAPS,
    parameter int unsigned      LOSS_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 chk_en,
    input  logic                 din,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    chk_state_t           r_fsm;
    logic [WIDTH-1:0]     r_chk_state;
    logic [5:0]           r_sync_cnt;
    logic [3:0]           r_consec;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 w_pred;
    logic                 w_mismatch;

    assign w_pred     = prbs_fb(32'(r_chk_state), 32'(TAPS));
    assign w_mismatch = din ^ w_pred;

    // Sync/lock state machine, local LFSR copy and error counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= SYNC;
            r_chk_state <= '0;
            r_sync_cnt  <= '0;
            r_consec    <= '0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_err <= 1'b0;
            if (chk_en) begin
                case (r_fsm)
                    SYNC: begin
                        r_chk_state <= {r_chk_state[WIDTH-2:0], din};
                        if (r_sync_cnt == 6'(WIDTH - 1)) begin
                            r_fsm      <= LOCK;
                            r_sync_cnt <= '0;
                        end else begin
                            r_sync_cnt <= r_sync_cnt + 6'd1;
                        end
                    end
                    LOCK: begin
                        r_chk_state <= {r_chk_state[WIDTH-2:0], w_pred};
                        if (w_mismatch) begin
                            r_err <= 1'b1;
                            if (r_err_cnt != {ERR_CNT_W{1'b1}}) begin
                                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                            end
                            if (r_consec == 4'(LOSS_THRESH - 1)) begin
                                r_fsm       <= SYNC;
                                r_chk_state <= '0;
                                r_sync_cnt  <= '0;
                                r_consec    <= '0;
                            end else begin
                                r_consec <= r_consec + 4'd1;
                            end
                        end else begin
                            r_consec <= '0;
                        end
                    end
                    default: r_fsm <= SYNC;
                endcase
            end
        end
    end

    assign locked  = (r_fsm == LOCK);
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: Fibonacci LFSR pattern generator plus an independent
// self-synchronising checker (prbs_chk).
// Optional build macro PRBS_ERR_INJECT_EN adds an err_inject input that
// inverts the freshly generated bit on dout for one step.
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS        = PRBS8_TAPS,
    parameter logic [WIDTH-1:0] SEED        = PRBS8_SEED,
    parameter int unsigned      LOSS_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gen_en,
    input  logic                 load,
    input  logic [WIDTH-1:0]     seed_in,
`ifdef PRBS_ERR_INJECT_EN
    input  logic                 err_inject,
`endif
    output logic                 dout,
    output logic [WIDTH-1:0]     gen_state,
    input  logic                 chk_en,
    input  logic                 din,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [WIDTH-1:0] r_state;
    logic             r_dout;
    logic [WIDTH-1:0] w_next_state;
    logic             w_fb;
    logic             w_inject;

    assign w_fb = prbs_fb(32'(r_state), 32'(TAPS));

`ifdef PRBS_ERR_INJECT_EN
    assign w_inject = err_inject & gen_en & ~load;
`else
    assign w_inject = 1'b0;
`endif

    // Next generator state: load wins over step; an all-zero load falls back to SEED
    always_comb begin
        w_next_state = r_state;
        if (load) begin
            w_next_state = (seed_in == '0) ? SEED : seed_in;
        end else if (gen_en) begin
            w_next_state = {r_state[WIDTH-2:0], w_fb};
        end
    end

    // Generator state and registered output bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
            r_dout  <= SEED[0];
        end else begin
            r_state <= w_next_state;
            r_dout  <= w_next_state[0] ^ w_inject;
        end
    end

    assign dout      = r_dout;
    assign gen_state = r_state;

    prbs_chk #(
        .WIDTH       (WIDTH),
        .TAPS        (TAPS),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .chk_en  (chk_en),
        .din     (din),
        .locked  (locked),
        .err     (err),
        .err_cnt (err_cnt)
    );

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: scoreboard bench for prbs_gen_chk. The driver updates a
// behavioural model and queues the expected outputs of every cycle; a monitor
// pops and compares after each rising edge.
`timescale 1ns/1ps
module tb_prbs_gen_chk;
    import prbs_pkg::*;

    localparam int              W       = 8;
    localparam logic [W-1:0]    TB_TAPS = 8'hB8;
    localparam logic [W-1:0]    TB_SEED = 8'h01;
    localparam int              THRESH  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         gen_en = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] seed_in = '0;
    logic         chk_en = 1'b0;
    logic         din = 1'b0;
    logic         dout;
    logic [W-1:0] gen_state;
    logic         locked;
    logic         err;
    logic [15:0]  err_cnt;
`ifdef PRBS_ERR_INJECT_EN
    logic         err_inject = 1'b0;
`endif

    always #5 clk = ~clk;

    prbs_gen_chk #(
        .WIDTH       (W),
        .TAPS        (TB_TAPS),
        .SEED        (TB_SEED),
        .LOSS_THRESH (THRESH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gen_en     (gen_en),
        .load       (load),
        .seed_in    (seed_in),
`ifdef PRBS_ERR_INJECT_EN
        .err_inject (err_inject),
`endif
        .dout       (dout),
        .gen_state  (gen_state),
        .chk_en     (chk_en),
        .din        (din),
        .locked     (locked),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    typedef struct {
        logic [W-1:0] gs;
        logic         dout;
        logic         locked;
        logic         err;
        logic [15:0]  cnt;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    // Behavioural model state
    logic [W-1:0] mGen    = TB_SEED;
    logic         mDout   = 1'b1;
    bit           mLocked = 1'b0;
    bit           mErr    = 1'b0;
    int           mCnt    = 0;
    int           mConsec = 0;
    bit           mWin[$];
    logic [W-1:0] mRef    = '0;
    bit           prevGenEn = 1'b0;

    function automatic bit parityOf(input logic [W-1:0] v);
        return bit'($countones(v & TB_TAPS) % 2);
    endfunction

    function automatic logic [W-1:0] advance(input logic [W-1:0] v);
        int unsigned n;
        n = (int'(v) * 2 + int'(parityOf(v))) % (1 << W);
        return W'(n);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit ge, input bit ld, input logic [W-1:0] sd,
                                 input bit ce, input bit d, input bit inj);
        exp_t e;
        bit   injUsed;
        bit   pred;
        @(negedge clk);
        rst     = r;
        gen_en  = ge;
        load    = ld;
        seed_in = sd;
        chk_en  = ce;
        din     = d;
`ifdef PRBS_ERR_INJECT_EN
        err_inject = inj;
        injUsed    = inj;
`else
        injUsed    = 1'b0;
`endif
        if (r) begin
            mGen = TB_SEED; mDout = TB_SEED[0];
            mLocked = 0; mErr = 0; mCnt = 0; mConsec = 0; mRef = '0;
            mWin.delete();
        end else begin
            if (ld) begin
                mGen  = (sd == '0) ? TB_SEED : sd;
                mDout = mGen[0];
            end else if (ge) begin
                mGen  = advance(mGen);
                mDout = mGen[0] ^ injUsed;
            end else begin
                mDout = mGen[0];
            end
            mErr = 0;
            if (ce) begin
                if (!mLocked) begin
                    mWin.push_back(d);
                    if (mWin.size() == W) begin
                        mRef = '0;
                        foreach (mWin[k]) mRef = W'(int'(mRef) * 2 + int'(mWin[k]));
                        mWin.delete();
                        mLocked = 1;
                    end
                end else begin
                    pred = parityOf(mRef);
                    mRef = advance(mRef);
                    if (d != pred) begin
                        mErr = 1;
                        if (mCnt < 65535) mCnt++;
                        mConsec++;
                        if (mConsec == THRESH) begin
                            mLocked = 0; mConsec = 0; mRef = '0;
                        end
                    end else begin
                        mConsec = 0;
                    end
                end
            end
        end
        prevGenEn = ge;
        e.gs = mGen; e.dout = mDout; e.locked = mLocked; e.err = mErr; e.cnt = 16'(mCnt);
        expQ.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic loopStep(input bit ge, input bit flip, input bit inj);
        applyStimulus(1'b0, ge, 1'b0, '0, prevGenEn, mDout ^ flip, inj);
    endtask

    task automatic loopValid(input int n, input bit gaps);
        int got = 0;
        bit ce;
        bit ge;
        while (got < n) begin
            ce = prevGenEn;
            ge = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            loopStep(ge, 1'b0, 1'b0);
            if (ce) got++;
        end
    endtask

    task automatic flipValid(input int k);
        int done = 0;
        bit ce;
        while (done < k) begin
            ce = prevGenEn;
            loopStep(1'b1, ce, 1'b0);
            if (ce) done++;
        end
    endtask

    // Monitor: compare every cycle's outputs with the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("gen_state", 32'(gen_state), 32'(e.gs));
                checkOutput("dout",      32'(dout),      32'(e.dout));
                checkOutput("locked",    32'(locked),    32'(e.locked));
                checkOutput("err",       32'(err),       32'(e.err));
                checkOutput("err_cnt",   32'(err_cnt),   32'(e.cnt));
            end
        end
    end

    initial begin
        logic [W-1:0] firstSteps [4];
        firstSteps[0] = 8'h02; firstSteps[1] = 8'h04; firstSteps[2] = 8'h08; firstSteps[3] = 8'h11;

        // Reset
        applyStimulus(1, 0, 0, '0, 0, 0, 0);
        applyStimulus(1, 0, 0, '0, 0, 0, 0);
        settle();
        checkOutput("rst_gen_state", 32'(gen_state), 32'h01);
        checkOutput("rst_dout",      32'(dout),      32'h1);
        checkOutput("rst_locked",    32'(locked),    32'h0);
        checkOutput("rst_err_cnt",   32'(err_cnt),   32'h0);

        // Seed progression and full period
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, '0, 0, 0, 0);
            settle();
            checkOutput("seed_step", 32'(gen_state), 32'(firstSteps[i]));
        end
        for (int i = 4; i < 255; i++) applyStimulus(0, 1, 0, '0, 0, 0, 0);
        settle();
        checkOutput("period_255", 32'(gen_state), 32'h01);

        // Load rules
        applyStimulus(0, 1, 1, 8'h5A, 0, 0, 0);
        settle();
        checkOutput("load_5a", 32'(gen_state), 32'h5A);
        applyStimulus(0, 0, 1, 8'h00, 0, 0, 0);
        settle();
        checkOutput("load_zero", 32'(gen_state), 32'h01);

        // Loopback lock, then 1000 bits with random gaps
        loopValid(8, 1'b0);
        settle();
        checkOutput("lock_after_8", 32'(locked), 32'h1);
        loopValid(1000, 1'b1);
        settle();
        checkOutput("clean_err_cnt", 32'(err_cnt), 32'h0);
        checkOutput("clean_locked",  32'(locked),  32'h1);

        // Single error
        flipValid(1);
        settle();
        checkOutput("single_err",    32'(err),     32'h1);
        checkOutput("single_cnt",    32'(err_cnt), 32'h1);
        checkOutput("single_locked", 32'(locked),  32'h1);
        loopValid(20, 1'b0);

        // Four consecutive errors: loss of lock, then relock
        flipValid(4);
        settle();
        checkOutput("loss_locked", 32'(locked), 32'h0);
        loopValid(8, 1'b0);
        settle();
        checkOutput("relock",       32'(locked),  32'h1);
        checkOutput("relock_count", 32'(err_cnt), 32'h5);
        loopValid(10, 1'b1);

`ifdef PRBS_ERR_INJECT_EN
        // Injected error in loopback
        loopStep(1'b1, 1'b0, 1'b1);
        loopStep(1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("inject_err",    32'(err),     32'h1);
        checkOutput("inject_locked", 32'(locked),  32'h1);
        checkOutput("inject_cnt",    32'(err_cnt), 32'h6);
        loopValid(10, 1'b0);
`endif

        // Saturation
        loopStep(1'b0, 1'b0, 1'b0);
        force dut.u_chk.r_err_cnt = 16'hFFFF;
        mCnt = 65535;
        expQ[expQ.size() - 1].cnt = 16'hFFFF;
        settle();
        #1;
        release dut.u_chk.r_err_cnt;
        flipValid(1);
        settle();
        checkOutput("sat_cnt",    32'(err_cnt), 32'hFFFF);
        checkOutput("sat_locked", 32'(locked),  32'h1);

        // Reset in the middle of LOCK
        applyStimulus(1, 1, 0, '0, 1, 0, 0);
        settle();
        checkOutput("midrst_locked", 32'(locked),    32'h0);
        checkOutput("midrst_cnt",    32'(err_cnt),   32'h0);
        checkOutput("midrst_gen",    32'(gen_state), 32'h01);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            bit r, ge, ld, ce, d, inj;
            r   = ($urandom_range(0, 99) == 0);
            ge  = ($urandom_range(0, 3) != 0);
            ld  = ($urandom_range(0, 19) == 0);
            ce  = ($urandom_range(0, 1) == 0) ? prevGenEn : bit'($urandom_range(0, 1));
            d   = ($urandom_range(0, 7) != 0) ? mDout : bit'($urandom_range(0, 1));
            inj = ($urandom_range(0, 31) == 0);
            applyStimulus(r, ge, ld, W'($urandom_range(0, 255)), ce, d, inj);
        end

        applyStimulus(0, 0, 0, '0, 0, 0, 0);
        settle();
        #2;
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prbs_gen_chk.md
Name: prbs_gen_chk

Overview:
- Parametrised XOR-feedback (Fibonacci LFSR) pseudo-random bit generator with a paired self-synchronising checker.
- Generalises the basic two-input XOR gate to an N-bit tap-masked XOR reduction driving registered shift state.
- Serves as a stimulus source and link/loopback checker for the gate-level and datapath blocks in this library.

Parameters:
- WIDTH, 8: LFSR length in bits; legal range 3..32.
- TAPS, 8'hB8: feedback tap mask, WIDTH bits wide; default is x^8+x^6+x^5+x^4+1 (maximal, period 255).
- SEED, 8'h01: generator reset/default state, WIDTH bits wide; must be nonzero.
- LOSS_THRESH, 4: consecutive checker errors that force loss of lock; legal range 1..15.

Ports:
- clk  in  1  Single system clock; all logic is on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- gen_en  in  1  Advances the generator by one step.
- load  in  1  Loads seed_in into the generator state.
- seed_in  in  WIDTH  Load value.
- dout  out  1  Generated bit; registered, equal to gen_state[0].
- gen_state  out  WIDTH  Current generator state.
- chk_en  in  1  din is valid this cycle.
- din  in  1  Received serial bit.
- locked  out  1  Checker is synchronised.
- err  out  1  One-cycle pulse on a mismatch.
- err_cnt  out  16  Saturating count of errors seen while locked.

Behaviour:
- Reset: rst is synchronous, active-high, and takes priority over every other input, including a reset asserted mid-operation. On reset: gen_state=SEED, dout=SEED[0], chk_state=0, sync_cnt=0, FSM=SYNC, locked=0, err=0, err_cnt=0, consecutive-error count=0.
- Feedback: fb(s) = XOR-reduce(s & TAPS). Step: s_next = {s[WIDTH-2:0], fb(s)}.
- Generator, priority load > gen_en:
  - load=1: gen_state <= seed_in. If seed_in==0, gen_state <= SEED instead (prevents all-zero lockup). No step that cycle, even if gen_en=1.
  - load=0, gen_en=1: gen_state <= step(gen_state).
  - Otherwise: gen_state holds.
  - Latency: a new bit appears on dout one cycle after gen_en.
- Checker FSM, two states; all transitions happen only on cycles with chk_en=1:
  - SYNC: chk_state <= {chk_state[WIDTH-2:0], din}; sync_cnt increments. When the WIDTH-th bit is sampled: go to LOCK, locked=1 from the next cycle, sync_cnt cleared. err is never asserted in SYNC.
  - LOCK: predicted = fb(chk_state); chk_state <= {chk_state[WIDTH-2:0], predicted}, so errors do not corrupt the state.
    - If din != predicted: err=1 on the next cycle; err_cnt increments and saturates at 16'hFFFF; consecutive count increments.
    - If din == predicted: consecutive count cleared.
    - When the consecutive count reaches LOSS_THRESH: go to SYNC, locked=0 on the next cycle, chk_state and counters cleared. err_cnt is retained.
- err deasserts on any cycle with no new mismatch, including cycles with chk_en=0.
- Generator and checker are independent. dout may be looped to din with chk_en=gen_en delayed by one cycle.
- Boundary conditions:
  - Generator returns to its seed after 2^WIDTH-1 steps for maximal taps.
  - chk_en gaps freeze the checker state.
  - err_cnt does not wrap.

Optional Feature:
- Macro: PRBS_ERR_INJECT_EN.
- Defined: adds input port err_inject (1 bit). When err_inject=1 and gen_en=1, dout takes the inverted value of the new bit for that cycle only. gen_state is unaffected, so the next step's dout is correct again.
- Undefined: the port is absent and dout is always gen_state[0].

Decomposition:
- Package prbs_pkg holds:
  - chk_state_t enum {SYNC, LOCK};
  - default TAPS/SEED constants for WIDTH 7, 8, 15, 16, 23, 31;
  - ERR_CNT_W=16.
- One sub-module, prbs_chk, contains the checker FSM and counters. The generator stays in the top module. Both share the fb function from prbs_pkg.

Test Plan:
- Seed progression: reset, then gen_en=1 for 4 cycles -> gen_state 01, 02, 04, 08, 11. After 255 total steps, gen_state==8'h01.
- Load rules: load=1, seed_in=8'h5A with gen_en=1 -> gen_state=8'h5A, no step. load with seed_in=0 -> gen_state=8'h01.
- Loopback lock: din=dout with chk_en as the delayed gen_en -> locked=1 after 8 valid bits, then 1000 bits with err=0 and err_cnt=0.
- Error counting: flip a single din bit while locked -> exactly one err pulse, err_cnt=1, locked stays 1. Flip 4 consecutive bits -> locked=0 on the cycle after the 4th, then relock after 8 more bits, err_cnt=5.
- Reset and saturation: rst mid-LOCK -> locked=0, err_cnt=0, gen_state=8'h01 on the next cycle. Forcing err_cnt to 16'hFFFF and injecting another error -> err_cnt holds at 16'hFFFF.
- Error injection (PRBS_ERR_INJECT_EN defined): err_inject=1 for one gen_en cycle in loopback -> one err pulse, no loss of lock.
